data_sync_mc: RTL
=================

Name: data_sync_mc

Overview:
- Multi-channel successor to the single-bus enable-qualified synchroniser.
- Receives NUM_CH independent source-domain buses, each with a qualifying enable, into the local clk domain.
- Per channel: a NUM_STAGES flop chain on the enable only, edge detection in level or toggle mode, and bus capture on the detected event.
- Adds per-channel valid/ready hold, overrun detection, and an ack toggle for the return handshake to the source domain.

Parameters:
- NUM_STAGES, 2, synchroniser depth on each enable; legal range 2..4.
- BUS_WIDTH, 8, data width per channel.
- NUM_CH, 4, number of independent channels; legal range 1..16.
- TOGGLE_MODE, 0, 0 = event on enable rising edge (level/pulse source); 1 = event on any enable edge (toggle source).
- OVERWRITE, 0, on overrun: 1 = new data replaces held data; 0 = new data dropped, held data kept.

Ports:
- clk  input  1  destination-domain clock.
- reset_n  input  1  synchronous, active-low reset.
- bus_enable  input  NUM_CH  asynchronous enable per channel; bit i belongs to channel i.
- unsync_bus  input  NUM_CH*BUS_WIDTH  asynchronous data; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH]. Must be stable from bus_enable assertion until ack_toggle for that channel changes.
- sync_ready  input  NUM_CH  downstream consumer accepts held data.
- clr_overrun  input  NUM_CH  clears the sticky overrun flag.
- enable_pulse  output  NUM_CH  one-cycle pulse per captured event.
- sync_bus  output  NUM_CH*BUS_WIDTH  captured data per channel, same packing as unsync_bus.
- sync_valid  output  NUM_CH  held data valid.
- overrun  output  NUM_CH  sticky flag: event arrived while data was still held.
- ack_toggle  output  NUM_CH  inverts on every event, for the source side to synchronise back.

Behaviour:

Reset:
- Reset is sampled only on a clk rising edge with reset_n = 0; it is synchronous, never asynchronous.
- All sync stages, edge-detect flops, enable_pulse, sync_bus, sync_valid, overrun and ack_toggle clear to 0.
- A reset asserted mid-transfer discards any in-flight event. No pulse is generated afterwards unless the enable shows a fresh qualifying edge after reset release.
- In level mode with the enable held high through reset release, an event occurs, because the chain resets to 0.

Synchroniser and edge detect (per channel, fully independent):
- bus_enable[i] passes through NUM_STAGES flops; the last stage is s.
- A flop s_d holds the previous value of s.
- The event is combinational: s & ~s_d when TOGGLE_MODE = 0; s ^ s_d when TOGGLE_MODE = 1.
- Only the enable is synchronised; the bus is never sampled through the flop chain.

Capture timing:
- If bus_enable rises before edge E0, then at edge E(NUM_STAGES) the following happen together:
  - sync_bus[i] <= unsync_bus[i];
  - enable_pulse[i] = 1 for exactly one cycle;
  - sync_valid[i] = 1;
  - ack_toggle[i] inverts.
- Latency is NUM_STAGES+1 edges from the first sampling edge.
- Example with NUM_STAGES = 2: enable high at the edge at 15 ns gives outputs after the edge at 35 ns.
- The enable held high for many cycles in level mode yields exactly one event.

Valid/ready hold:
- sync_valid and sync_bus hold until an edge where sync_valid & sync_ready; sync_valid then clears.
- Event and acceptance at the same edge: new data loads, sync_valid stays 1, no overrun.
- Event while sync_valid = 1 and sync_ready = 0:
  - overrun is set;
  - enable_pulse and ack_toggle still fire;
  - sync_bus is replaced if OVERWRITE = 1, otherwise it is unchanged;
  - sync_valid stays 1.
- overrun stays set until an edge with clr_overrun = 1.
- clr_overrun together with a new overrun event at the same edge: overrun stays 1, because set wins.

Structure:
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then ch0 bus_enable = 1 for 2 cycles with bus 8'h11, sync_ready = 1 -> at edge 3 after assertion: enable_pulse[0] = 1 for one cycle, sync_bus[0] = 8'h11, ack_toggle[0] = 1; no activity on other channels.
2. ch1 enable high for 1 cycle with bus 8'hF1 while ch2 enable is high with 8'hA5 one cycle later -> independent pulses one cycle apart; sync_bus = F1 on ch1 and A5 on ch2; no crosstalk.
3. sync_ready[0] = 0, two events on ch0 with 8'h01 then 8'h02 -> overrun[0] = 1 and sync_valid[0] = 1. Held data is 8'h01 with OVERWRITE = 0 and 8'h02 with OVERWRITE = 1. Pulsing clr_overrun clears the flag.
4. TOGGLE_MODE = 1: toggle ch3 enable 0->1->0, with bus 8'h33 then 8'h44, at 6-cycle spacing -> two pulses; sync_bus[3] = 33 then 44; ack_toggle[3] returns to 0.
5. Level mode with the enable held high for 20 cycles -> exactly one enable_pulse. Assert reset_n = 0 for one edge mid-chain on a new event -> no pulse is produced and all outputs read 0.
6. NUM_STAGES = 3, NUM_CH = 1 build -> capture latency is 4 edges; event and sync_ready at the same edge keep sync_valid = 1 with no overrun.

Source files
------------

// File: rtl/data_sync_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sync_mc: per-channel enable synchroniser with qualified bus capture, |
// | valid/ready hold, sticky overrun and ack toggle.   Revision: 1.0         |
// +--------------------------------------------------------------------------+
module data_sync_mc #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int OVERWRITE   = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           sync_ready,
    input  logic [NUM_CH-1:0]           clr_overrun,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           sync_valid,
    output logic [NUM_CH-1:0]           overrun,
    output logic [NUM_CH-1:0]           ack_toggle
);

    localparam bit C_OVERWRITE = (OVERWRITE != 0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_STAGES-1:0] r_chain;
        logic                  r_sd;
        logic                  r_pulse;
        logic                  r_ack;
        logic                  r_valid;
        logic                  r_ovr;
        logic [BUS_WIDTH-1:0]  r_bus;
        logic                  w_s;
        logic                  w_event;
        logic                  w_busy;

        assign w_s    = r_chain[NUM_STAGES-1];
        assign w_busy = r_valid & ~sync_ready[i];

        if (TOGGLE_MODE != 0) begin : g_toggle
            assign w_event = w_s ^ r_sd;
        end else begin : g_level
            assign w_event = w_s & ~r_sd;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_chain <= '0;
                r_sd    <= 1'b0;
                r_pulse <= 1'b0;
                r_ack   <= 1'b0;
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
                r_bus   <= '0;
            end else begin
                r_chain <= {r_chain[NUM_STAGES-2:0], bus_enable[i]};
                r_sd    <= w_s;
                r_pulse <= w_event;
                r_ack   <= r_ack ^ w_event;

                // A blocked event only replaces held data when overwriting is enabled
                if (w_event) begin
                    if (!w_busy || C_OVERWRITE) begin
                        r_bus <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
                    end
                    r_valid <= 1'b1;
                end else if (sync_ready[i]) begin
                    r_valid <= 1'b0;
                end

                // Set has priority over clear
                if (w_event && w_busy) begin
                    r_ovr <= 1'b1;
                end else if (clr_overrun[i]) begin
                    r_ovr <= 1'b0;
                end
            end
        end

        assign enable_pulse[i]                       = r_pulse;
        assign ack_toggle[i]                         = r_ack;
        assign sync_valid[i]                         = r_valid;
        assign overrun[i]                            = r_ovr;
        assign sync_bus[i*BUS_WIDTH +: BUS_WIDTH]    = r_bus;
    end

endmodule
`default_nettype wire
